// File: rtl/sar_capture_ctrl.sv
// sar_capture_ctrl: system-clock back-end for the SAR ADC core.
// Runs the sample/convert sequence on adc_clk, synchronizes the asynchronous
// compl flag, captures adc_data, converts offset binary to two's complement
// and buffers results in a small FIFO with a valid/ready output stream.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   enable            run back-to-back conversions while high
//   adc_clk           conversion clock to the core (high = sample)
//   compl, adc_data   completion flag (asynchronous) and offset-binary result
//   dout, dout_valid  FIFO head (two's complement) and non-empty flag
//   dout_ready        consumer handshake; pop on dout_valid && dout_ready
//   overflow_cnt      saturating count of results dropped on a full FIFO
//   timeout_err       sticky conversion-timeout flag
//   err_clr           synchronous clear of timeout_err and overflow_cnt
//
// Optional feature: define SAR_CAPTURE_AVG_EN to push the floor-average of
// every four converted samples instead of each individual sample.
module sar_capture_ctrl #(
    parameter int unsigned ADC_BITS    = 8,
    parameter int unsigned SAMPLE_CYC  = 4,
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    output logic                adc_clk,
    input  logic                compl,
    input  logic [ADC_BITS-1:0] adc_data,
    output logic [ADC_BITS-1:0] dout,
    output logic                dout_valid,
    input  logic                dout_ready,
    output logic [7:0]          overflow_cnt,
    output logic                timeout_err,
    input  logic                err_clr
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SCNT_W = 8;
    localparam int unsigned TMO_W  = 16;

    typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, CAPTURE} state_e;

    state_e                  state_q, state_d;
    logic [SCNT_W-1:0]       smp_cnt_q, smp_cnt_d;
    logic [TMO_W-1:0]        tmo_cnt_q, tmo_cnt_d;
    logic [ADC_BITS-1:0]     cap_q, cap_d;
    logic                    adc_clk_q;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    compl_s_d_q;
    logic                    compl_rise_c;
    logic                    tmo_evt_c;
    logic [ADC_BITS-1:0]     conv_c;
    logic                    push_c;
    logic [ADC_BITS-1:0]     push_data_c;

    logic [ADC_BITS-1:0]     mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d, left_c;
    logic [ADC_BITS-1:0]     dout_q, dout_d;
    logic                    dout_valid_q;
    logic                    pop_c, accept_c, drop_c;
    logic [7:0]              ovf_q, ovf_d;
    logic                    tmo_err_q, tmo_err_d;

    // compl synchronizer and rising-edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= '0;
            compl_s_d_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], compl};
            compl_s_d_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign compl_rise_c = sync_q[SYNC_STAGES-1] && !compl_s_d_q;
    assign conv_c       = {~cap_q[ADC_BITS-1], cap_q[ADC_BITS-2:0]};

    // Conversion sequencer next-state logic
    always_comb begin
        state_d   = state_q;
        smp_cnt_d = smp_cnt_q;
        tmo_cnt_d = tmo_cnt_q;
        cap_d     = cap_q;
        tmo_evt_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d   = SAMPLE;
                    smp_cnt_d = SCNT_W'(SAMPLE_CYC - 1);
                end
            end
            SAMPLE: begin
                if (smp_cnt_q == '0) begin
                    state_d   = CONVERT;
                    tmo_cnt_d = '0;
                end else begin
                    smp_cnt_d = smp_cnt_q - SCNT_W'(1);
                end
            end
            CONVERT: begin
                // a completion in the last allowed cycle still counts
                if (compl_rise_c) begin
                    cap_d   = adc_data;
                    state_d = CAPTURE;
                end else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                    tmo_evt_c = 1'b1;
                    state_d   = IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            CAPTURE: begin
                if (enable) begin
                    state_d   = SAMPLE;
                    smp_cnt_d = SCNT_W'(SAMPLE_CYC - 1);
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            smp_cnt_q <= '0;
            tmo_cnt_q <= '0;
            cap_q     <= '0;
            adc_clk_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            smp_cnt_q <= smp_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
            cap_q     <= cap_d;
            adc_clk_q <= (state_d == SAMPLE);
        end
    end

`ifdef SAR_CAPTURE_AVG_EN
    localparam int unsigned ACC_W = ADC_BITS + 2;

    logic signed [ACC_W-1:0] acc_q, acc_d, sum_c;
    logic [1:0]              avg_cnt_q, avg_cnt_d;

    // Four-sample accumulator; a partial sum is dropped once enable is low in IDLE
    always_comb begin
        acc_d       = acc_q;
        avg_cnt_d   = avg_cnt_q;
        push_c      = 1'b0;
        push_data_c = '0;
        sum_c       = acc_q + {{2{conv_c[ADC_BITS-1]}}, conv_c};
        if (state_q == IDLE && !enable) begin
            acc_d     = '0;
            avg_cnt_d = '0;
        end else if (state_q == CAPTURE) begin
            if (avg_cnt_q == 2'd3) begin
                push_c      = 1'b1;
                push_data_c = ADC_BITS'(sum_c >>> 2);
                acc_d       = '0;
                avg_cnt_d   = '0;
            end else begin
                acc_d     = sum_c;
                avg_cnt_d = avg_cnt_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            avg_cnt_q <= '0;
        end else begin
            acc_q     <= acc_d;
            avg_cnt_q <= avg_cnt_d;
        end
    end
`else
    assign push_c      = (state_q == CAPTURE);
    assign push_data_c = conv_c;
`endif

    // FIFO control; a pop frees the slot for a same-cycle push when full
    always_comb begin
        pop_c    = dout_valid_q && dout_ready;
        accept_c = push_c && ((cnt_q != CNT_W'(FIFO_DEPTH)) || pop_c);
        drop_c   = push_c && !accept_c;
        rd_ptr_d = pop_c ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d = accept_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        left_c   = pop_c ? cnt_q - CNT_W'(1) : cnt_q;
        cnt_d    = accept_c ? left_c + CNT_W'(1) : left_c;
        // next head: bypass the incoming word when nothing else remains
        if (left_c == '0) begin
            dout_d = accept_c ? push_data_c : dout_q;
        end else begin
            dout_d = mem_q[rd_ptr_d];
        end
        ovf_d     = ovf_q;
        tmo_err_d = tmo_err_q;
        if (drop_c) begin
            ovf_d = (ovf_q == 8'hFF) ? ovf_q : ovf_q + 8'd1;
        end else if (err_clr) begin
            ovf_d = '0;
        end
        if (tmo_evt_c) begin
            tmo_err_d = 1'b1;
        end else if (err_clr) begin
            tmo_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept_c) begin
            mem_q[wr_ptr_q] <= push_data_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            cnt_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            ovf_q        <= '0;
            tmo_err_q    <= 1'b0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            cnt_q        <= cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= (cnt_d != '0);
            ovf_q        <= ovf_d;
            tmo_err_q    <= tmo_err_d;
        end
    end

    assign adc_clk      = adc_clk_q;
    assign dout         = dout_q;
    assign dout_valid   = dout_valid_q;
    assign overflow_cnt = ovf_q;
    assign timeout_err  = tmo_err_q;

endmodule

// File: tb/tb_sar_capture_ctrl.sv
// tb_sar_capture_ctrl: randomized self-checking bench for sar_capture_ctrl.
// A behavioural SAR core answers each conversion with a queued code; expected
// output words are derived arithmetically (code - 128, optional floor-average
// of four) into a scoreboard queue that every popped dout is compared against.
`timescale 1ns/1ps
module tb_sar_capture_ctrl;

    localparam int unsigned ADC_BITS    = 8;
    localparam int unsigned SAMPLE_CYC  = 4;
    localparam int unsigned TIMEOUT_CYC = 64;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned FIFO_DEPTH  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       compl = 1'b0;
    logic [7:0] adc_data = 8'h00;
    logic       dout_ready = 1'b0;
    logic       err_clr = 1'b0;
    logic       adc_clk;
    logic [7:0] dout;
    logic       dout_valid;
    logic [7:0] overflow_cnt;
    logic       timeout_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sar_capture_ctrl #(
        .ADC_BITS   (ADC_BITS),
        .SAMPLE_CYC (SAMPLE_CYC),
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .SYNC_STAGES(SYNC_STAGES),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .adc_clk     (adc_clk),
        .compl       (compl),
        .adc_data    (adc_data),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .overflow_cnt(overflow_cnt),
        .timeout_err (timeout_err),
        .err_clr     (err_clr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] core_codes[$];
    logic [7:0] exp_q[$];
    int  core_delay = 20;
    bit  rand_delay = 1'b0;
    bit  rand_ready = 1'b0;
    bit  hold_mode  = 1'b0;
    bit  squash     = 1'b0;
    int  n_compl    = 0;
    int  n_samp     = 0;
    int  exp_drops  = 0;
    int  acc        = 0;
    int  acc_n      = 0;

    function automatic void model_capture(input logic [7:0] code);
        int         val;
        logic [7:0] word;
        val = int'(code) - 128;
`ifdef SAR_CAPTURE_AVG_EN
        acc   = acc + val;
        acc_n = acc_n + 1;
        if (acc_n < 4) return;
        word  = 8'(acc >>> 2);
        acc   = 0;
        acc_n = 0;
`else
        word = 8'(val);
`endif
        // hold_mode: no pops expected, so the model alone decides drops
        if (hold_mode && exp_q.size() >= FIFO_DEPTH) exp_drops++;
        else exp_q.push_back(word);
    endfunction

    function automatic void model_flush();
        acc   = 0;
        acc_n = 0;
    endfunction

    // Behavioural SAR core: answers a conversion only when a code is queued
    initial begin
        forever begin
            @(negedge adc_clk);
            if (core_codes.size() > 0) begin
                logic [7:0] c;
                int         d;
                c = core_codes.pop_front();
                d = rand_delay ? int'($urandom_range(1, 40)) : core_delay;
                repeat (d) @(posedge clk);
                #2;
                adc_data = c;
                compl    = 1'b1;
                n_compl++;
                if (!squash) model_capture(c);
                @(posedge adc_clk);
                #1 compl = 1'b0;
            end
        end
    end

    always @(posedge adc_clk) n_samp++;

    always @(posedge clk) begin
        if (rand_ready) begin
            #1 dout_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Output monitor: scoreboard on every pop, adc_clk high-phase length
    int hi_run = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (dout_valid && dout_ready) begin
                if (exp_q.size() == 0) check("pop_unexpected", 32'd1, 32'd0);
                else check("dout", dout, exp_q.pop_front());
            end
            if (adc_clk) hi_run++;
            else if (hi_run > 0) begin
                check("adc_clk_high", hi_run, SAMPLE_CYC);
                hi_run = 0;
            end
        end else begin
            hi_run = 0;
        end
    end

    task automatic run_convs(input int n);
        int target;
        int cyc;
        target = n_compl + n;
        cyc    = 0;
        enable = 1'b1;
        while (n_compl < target && cyc < 5000) begin
            @(posedge clk); #1;
            cyc++;
        end
        enable = 1'b0;
        check("run_convs_done", 32'(n_compl >= target), 32'd1);
        repeat (10) @(posedge clk);
        #1;
        model_flush();
    endtask

    task automatic wait_cycles_drain();
        dout_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int n;
        int samp0;
        int ovf0;

        // reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_adc_clk", adc_clk, 0);
        check("rst_dout", dout, 0);
        check("rst_valid", dout_valid, 0);
        check("rst_ovf", overflow_cnt, 0);
        check("rst_tmo", timeout_err, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

`ifndef SAR_CAPTURE_AVG_EN
        // basic conversion then code extremes, held in the FIFO
        hold_mode  = 1'b1;
        dout_ready = 1'b0;
        core_codes.push_back(8'hA5);
        run_convs(1);
        check("basic_valid", dout_valid, 1);
        check("basic_dout", dout, 8'h25);
        core_codes.push_back(8'h00);
        core_codes.push_back(8'hFF);
        run_convs(2);
        wait_cycles_drain();
        check("extreme_drained", dout_valid, 0);
        check("extreme_left", exp_q.size(), 0);
`else
        // four-sample average
        hold_mode  = 1'b1;
        dout_ready = 1'b0;
        core_codes.push_back(8'h90);
        core_codes.push_back(8'h90);
        core_codes.push_back(8'h91);
        core_codes.push_back(8'h91);
        run_convs(4);
        check("avg_valid", dout_valid, 1);
        check("avg_dout", dout, 8'h10);
        wait_cycles_drain();
        check("avg_drained", dout_valid, 0);
        check("avg_left", exp_q.size(), 0);
`endif

        // timeout: no core response
        hold_mode = 1'b0;
        enable    = 1'b1;
        cyc = 0;
        while (!adc_clk && cyc < 100) begin @(posedge clk); #1; cyc++; end
        while (adc_clk && cyc < 100) begin @(posedge clk); #1; cyc++; end
        check("tmo_enter_convert", 32'(cyc < 100), 32'd1);
        n = 0;
        while (!timeout_err && n < 200) begin @(posedge clk); #1; n++; end
        check("tmo_cycles", n, TIMEOUT_CYC);
        check("tmo_no_push", dout_valid, 0);
        cyc = 0;
        while (!adc_clk && cyc < 5) begin @(posedge clk); #1; cyc++; end
        check("tmo_restart", adc_clk, 1);
        // enable drop mid-SAMPLE: this conversion still completes
        samp0 = n_samp;
        core_codes.push_back(8'h3C);
        enable = 1'b0;
        repeat (80) @(posedge clk);
        #1;
        model_flush();
        check("drop_no_resample", n_samp, samp0);
        check("drop_idle_adc_clk", adc_clk, 0);
        check("drop_left", exp_q.size(), 0);
        check("tmo_sticky", timeout_err, 1);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        check("tmo_clear", timeout_err, 0);

`ifndef SAR_CAPTURE_AVG_EN
        // overflow: six conversions into a four-entry FIFO with no pops
        hold_mode  = 1'b1;
        dout_ready = 1'b0;
        exp_drops  = 0;
        for (int i = 0; i < 6; i++) core_codes.push_back(8'($urandom));
        run_convs(6);
        check("ovf_cnt", overflow_cnt, exp_drops);
        check("ovf_cnt_two", overflow_cnt, 2);
        check("ovf_valid", dout_valid, 1);
        // full FIFO: push and pop in the same cycle
        hold_mode = 1'b0;
        ovf0 = exp_drops;
        core_codes.push_back(8'($urandom));
        enable = 1'b1;
        cyc = 0;
        while (!compl && cyc < 200) begin @(posedge clk); #1; cyc++; end
        check("simul_compl_seen", compl, 1);
        enable = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 dout_ready = 1'b1;
        @(posedge clk);
        #1 dout_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("simul_ovf_same", overflow_cnt, ovf0);
        check("simul_valid", dout_valid, 1);
        wait_cycles_drain();
        check("ovf_drained", dout_valid, 0);
        check("ovf_left", exp_q.size(), 0);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        check("ovf_clear", overflow_cnt, 0);
`endif

        // asynchronous reset mid-CONVERT with a non-empty FIFO
        hold_mode  = 1'b1;
        dout_ready = 1'b0;
        core_codes.push_back(8'($urandom));
        core_codes.push_back(8'($urandom));
        run_convs(2);
        squash     = 1'b1;
        core_delay = 40;
        core_codes.push_back(8'h5A);
        enable = 1'b1;
        cyc = 0;
        while (!adc_clk && cyc < 100) begin @(posedge clk); #1; cyc++; end
        while (adc_clk && cyc < 100) begin @(posedge clk); #1; cyc++; end
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("rstc_adc_clk", adc_clk, 0);
        check("rstc_valid", dout_valid, 0);
        check("rstc_dout", dout, 0);
        check("rstc_ovf", overflow_cnt, 0);
        check("rstc_tmo", timeout_err, 0);
        exp_q.delete();
        model_flush();
        enable = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        squash     = 1'b0;
        core_delay = 20;
        check("rstc_fifo_empty", dout_valid, 0);

        // randomized traffic with random consumer back-pressure
        hold_mode  = 1'b0;
        rand_delay = 1'b1;
        rand_ready = 1'b1;
        for (int i = 0; i < 24; i++) core_codes.push_back(8'($urandom));
        run_convs(24);
        rand_ready = 1'b0;
        @(posedge clk);
        #2;
        wait_cycles_drain();
        check("rand_drained", dout_valid, 0);
        check("rand_left", exp_q.size(), 0);
        check("rand_ovf", overflow_cnt, 0);
        check("rand_tmo", timeout_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
